// File: rtl/operand_fetch_pkg.sv
// Operand-fetch shared definitions.
// Holds the default data/tag widths, the register index width and the FSM state encoding
// so the RTL and the bench agree. It also holds the writeback-hit helper used by both
// operand paths.
package operand_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // A writeback targets this index. x0 is never a hit.
    function automatic logic wb_hits(input logic              we,
                                     input logic [REG_AW-1:0] wa,
                                     input logic [REG_AW-1:0] idx);
        return we && (wa == idx) && (idx != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Operand-fetch bus: the request port from decode, the register-file read port, the
// writeback snoop and the operand port to execute.
//   master : environment side (decode, register file, writeback, execute)
//   slave  : operand_fetch side
interface operand_fetch_if #(
    parameter int unsigned XLEN  = operand_fetch_pkg::XLEN,
    parameter int unsigned TAG_W = operand_fetch_pkg::TAG_W
) ();
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [TAG_W-1:0] req_tag;

    logic [4:0]       rf_addr1;
    logic [4:0]       rf_addr2;
    logic [XLEN-1:0]  rf_rs1;
    logic [XLEN-1:0]  rf_rs2;

    logic             wb_write;
    logic [4:0]       wb_addr;
    logic [XLEN-1:0]  wb_data;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_rs1;
    logic [XLEN-1:0]  out_rs2;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output req_valid, req_rs1, req_rs2, req_tag,
        output rf_rs1, rf_rs2,
        output wb_write, wb_addr, wb_data,
        output out_ready,
        input  req_ready, rf_addr1, rf_addr2,
        input  out_valid, out_rs1, out_rs2, out_tag
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_tag,
        input  rf_rs1, rf_rs2,
        input  wb_write, wb_addr, wb_data,
        input  out_ready,
        output req_ready, rf_addr1, rf_addr2,
        output out_valid, out_rs1, out_rs2, out_tag
    );
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// One operand path of operand_fetch: captures the register-file word and applies writeback
// forwarding so the held operand is never stale.
//   clk, rst        clock, async active-high reset
//   accept          request accepted this cycle (req_idx is the new index)
//   fetch           FETCH cycle: capture the operand
//   hold            VALID and not consumed: track writes to idx
//   req_idx, idx    incoming index (accept cycle) and latched index
//   rf_data         register-file read data (valid in FETCH)
//   wb_write/addr/data  writeback snoop
//   operand         held operand register
//   fwd             a write hit the accept cycle; fwd data overrides rf_data in FETCH
module operand_fetch_fwd_mux #(
    parameter int unsigned XLEN   = operand_fetch_pkg::XLEN,
    parameter int unsigned REG_AW = operand_fetch_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              fetch,
    input  logic              hold,
    input  logic [REG_AW-1:0] req_idx,
    input  logic [REG_AW-1:0] idx,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              wb_write,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   operand,
    output logic              fwd
);
    import operand_fetch_pkg::*;

    logic [XLEN-1:0] operand_q, operand_d;
    logic [XLEN-1:0] fwd_data_q, fwd_data_d;
    logic            fwd_q, fwd_d;
    logic            hit_req, hit_idx;

    assign hit_req = wb_hits(wb_write, wb_addr, req_idx);
    assign hit_idx = wb_hits(wb_write, wb_addr, idx);

    always_comb begin
        operand_d  = operand_q;
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        if (accept) begin
            // The register file reads at this edge without bypass, so keep the write aside.
            fwd_d = hit_req;
            if (hit_req) begin
                fwd_data_d = wb_data;
            end
        end else if (fetch) begin
            fwd_d = 1'b0;
            if (idx == '0) begin
                operand_d = '0;
            end else if (hit_idx) begin
                operand_d = wb_data;
            end else if (fwd_q) begin
                operand_d = fwd_data_q;
            end else begin
                operand_d = rf_data;
            end
        end else if (hold && hit_idx) begin
            operand_d = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand_q  <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            operand_q  <= operand_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign operand = operand_q;
    assign fwd     = fwd_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts rs1/rs2/tag requests, reads the 1-cycle register file, and
// forwards in-flight writebacks. It presents both operands to execute under valid/ready.
//   clk, rst  clock, async active-high reset
//   bus       operand_fetch_if.slave: request, register-file read, writeback snoop,
//             operand output
// Sequence: IDLE -> (accept) FETCH -> VALID -> (consume) IDLE, or FETCH when a new
// request is accepted at the same edge. This gives one response every 2 cycles.
module operand_fetch #(
    parameter int unsigned XLEN  = operand_fetch_pkg::XLEN,
    parameter int unsigned TAG_W = operand_fetch_pkg::TAG_W
) (
    input logic            clk,
    input logic            rst,
    operand_fetch_if.slave bus
);
    import operand_fetch_pkg::*;

    logic [1:0]        state_q, state_d;
    logic              req_ready, accept, fetch, hold, consume;
    logic [REG_AW-1:0] idx1_q, idx2_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   rs1, rs2;
    logic              fwd1, fwd2;

    assign consume   = (state_q == ST_VALID) && bus.out_ready;
    assign req_ready = (state_q == ST_IDLE) || consume;
    assign accept    = bus.req_valid && req_ready;
    assign fetch     = (state_q == ST_FETCH);
    assign hold      = (state_q == ST_VALID) && !bus.out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_VALID;
            ST_VALID: if (bus.out_ready) state_d = bus.req_valid ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx1_q  <= '0;
            idx2_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx1_q <= bus.req_rs1;
                idx2_q <= bus.req_rs2;
                tag_q  <= bus.req_tag;
            end
        end
    end

    operand_fetch_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_mux1 (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .fetch    (fetch),
        .hold     (hold),
        .req_idx  (bus.req_rs1),
        .idx      (idx1_q),
        .rf_data  (bus.rf_rs1),
        .wb_write (bus.wb_write),
        .wb_addr  (bus.wb_addr),
        .wb_data  (bus.wb_data),
        .operand  (rs1),
        .fwd      (fwd1)
    );

    operand_fetch_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_mux2 (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .fetch    (fetch),
        .hold     (hold),
        .req_idx  (bus.req_rs2),
        .idx      (idx2_q),
        .rf_data  (bus.rf_rs2),
        .wb_write (bus.wb_write),
        .wb_addr  (bus.wb_addr),
        .wb_data  (bus.wb_data),
        .operand  (rs2),
        .fwd      (fwd2)
    );

    // A forward flag only lives across the accept->FETCH edge.
    fwd_only_in_fetch: assert property (@(posedge clk) disable iff (rst)
        (fwd1 || fwd2) |-> (state_q == ST_FETCH));

    // Register-file addresses follow the request combinationally in the accept cycle.
    assign bus.rf_addr1  = accept ? bus.req_rs1 : idx1_q;
    assign bus.rf_addr2  = accept ? bus.req_rs2 : idx2_q;
    assign bus.req_ready = req_ready;
    assign bus.out_valid = (state_q == ST_VALID);
    assign bus.out_rs1   = rs1;
    assign bus.out_rs2   = rs2;
    assign bus.out_tag   = tag_q;

endmodule
